condlogic_pipe: RTL
===================

// Module: condlogic_pipe
// PURPOSE
//  Parametrised conditional-execution unit for the multicycle ARM core. It holds the NZCV
//  flags, evaluates all 16 condition codes and gates RegWrite/MemWrite/PCWrite. Flag
//  writeback runs through a WB_DELAY-stage pipeline, with hazard stall, flag save/restore
//  and optional flag forwarding. Sits between the controller FSM and the datapath ALU.
// PARAMETERS
//  WB_DELAY  1  cycles from FlagW qualification to the flag-register update (0..4)
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  Cond         in   4  instruction condition field
//  ALUFlags     in   4  {N,Z,C,V} from the ALU
//  FlagW        in   2  [1]=write N,Z  [0]=write C,V
//  PCS          in   1  instruction writes PC
//  NextPC       in   1  FSM fetch-advance request
//  RegW         in   1  FSM register-write request
//  MemW         in   1  FSM memory-write request
//  FlagSave     in   1  copy Flags into the shadow register
//  FlagRestore  in   1  load Flags from the shadow register
//  PCWrite      out  1  qualified PC write
//  RegWrite     out  1  qualified register write
//  MemWrite     out  1  qualified memory write
//  CondEx       out  1  condition passed (comb.)
//  CondStall    out  1  hazard: FSM must hold the current state
//  Flags        out  4  architectural NZCV
// BEHAVIOUR
//  - Reset (reset=0, async): Flags=0, shadow=0, all pend stages=0; all write outputs and CondStall=0.
//  - Cond decode: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z,
//    GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL(1110)=1, 1111=0 (NV, never x).
//  - EffFlags = Flags (see the forwarding macro). CondEx = decode(Cond, EffFlags).
//  - Qualify: q = CondEx & ~CondStall. RegWrite=RegW&q. MemWrite=MemW&q.
//    PCWrite = (NextPC & ~CondStall) | (PCS & q).
//  - Pipeline: pend[1] <= FlagW & {2{q}}; pend[k] <= pend[k-1], k=2..WB_DELAY.
//    At the last stage, Flags[3:2]<=ALUFlags[3:2] if pend[WB_DELAY][1]; Flags[1:0]<=ALUFlags[1:0] if [0].
//    WB_DELAY=0: no stages; the update uses FlagW&{2{CondEx}} in the same edge; CondStall is always 0.
//  - Hazard: CondStall = (any pend stage nonzero) & Cond!=AL & Cond!=NV.
//    A stalled instruction issues no writes and no pend entry. The pipeline keeps draining.
//  - Save/restore: FlagSave captures the pre-edge Flags. Priority on Flags per edge:
//    FlagRestore > pipeline write > hold. Restore and save together: the shadow gets old Flags
//    and Flags gets the old shadow (swap).
//  - A pending write that lands after a restore overwrites only its own groups.
//  - Async reset mid-pipeline discards all pending writes.
// CONFIGURATION
//  CONDLOGIC_FLAG_FWD_EN defined:
//   - EffFlags takes ALUFlags per group where pend[WB_DELAY] is set, otherwise Flags.
//   - The last stage is excluded from the CondStall term, so WB_DELAY=1 never stalls.
//   - When FlagRestore is set in the same cycle, forwarding is suppressed for that cycle
//     and EffFlags = Flags.
//  CONDLOGIC_FLAG_FWD_EN undefined:
//   - EffFlags = Flags; every nonzero stage counts toward CondStall.
// TESTING
//  1 Reset: hold reset=0 with RegW=MemW=PCS=NextPC=1 -> all write outputs 0, Flags=0000.
//    Release with Cond=1110 -> RegWrite=MemWrite=PCWrite=1.
//  2 Decode sweep: for each Flags value 0..15 and Cond 0..15, CondEx matches the table.
//    Cond=1111 always gives 0.
//  3 WB_DELAY=1, no FWD: cycle0 ALUFlags=0100, FlagW=11, Cond=AL; cycle1 Cond=0000(EQ)
//    -> CondStall=1 and RegWrite=0. Cycle2: Flags=0100, CondStall=0, CondEx=1.
//  4 Same stimulus with CONDLOGIC_FLAG_FWD_EN -> cycle1 CondStall=0, CondEx=1, RegWrite=1.
//  5 Flags=1001, FlagSave=1; load Flags=0110 via FlagW; then FlagRestore=1 -> Flags=1001.
//    Restore together with a pending write -> restore wins.
//  6 WB_DELAY=3: FlagW=01 with Cond=0001 failing -> no pend entry and Flags unchanged.
//    Drop reset while pend[2]!=0 -> Flags=0000 and pend cleared.

Source files
------------

// File: rtl/condlogic_pipe.sv
// Conditional-execution unit: NZCV flags, 16-way condition decode, write gating, and a
// WB_DELAY-stage flag writeback pipeline with hazard stall and shadow save/restore.
// Optional flag forwarding is enabled by defining CONDLOGIC_FLAG_FWD_EN.
module condlogic_pipe #(
    parameter int WB_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       FlagSave,
    input  logic       FlagRestore,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondStall,
    output logic [3:0] Flags
);

    localparam int PD = (WB_DELAY < 1) ? 1 : WB_DELAY;
`ifdef CONDLOGIC_FLAG_FWD_EN
    localparam int LAST_COUNTED = WB_DELAY - 1;
`else
    localparam int LAST_COUNTED = WB_DELAY;
`endif

    logic [3:0] r_flags;
    logic [3:0] r_shadow;
    logic [1:0] r_pend [1:PD];

    logic [1:0] w_fwd;
    logic [1:0] w_land;
    logic [3:0] w_effFlags;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond;
    logic       w_anyPend;
    logic       w_stall;
    logic       w_qual;

    // Forwarding substitutes the ALU flags of groups landing this cycle, unless a restore
    // overrides the architectural flags in the same cycle.
    always_comb begin
        w_fwd = 2'b00;
`ifdef CONDLOGIC_FLAG_FWD_EN
        if (WB_DELAY > 0 && !FlagRestore) begin
            w_fwd = r_pend[PD];
        end
`endif
        w_effFlags[3:2] = w_fwd[1] ? ALUFlags[3:2] : r_flags[3:2];
        w_effFlags[1:0] = w_fwd[0] ? ALUFlags[1:0] : r_flags[1:0];
    end

    assign {w_n, w_z, w_c, w_v} = w_effFlags;

    always_comb begin
        w_cond = 1'b0;
        case (Cond)
            4'b0000: w_cond = w_z;
            4'b0001: w_cond = !w_z;
            4'b0010: w_cond = w_c;
            4'b0011: w_cond = !w_c;
            4'b0100: w_cond = w_n;
            4'b0101: w_cond = !w_n;
            4'b0110: w_cond = w_v;
            4'b0111: w_cond = !w_v;
            4'b1000: w_cond = w_c && !w_z;
            4'b1001: w_cond = !w_c || w_z;
            4'b1010: w_cond = (w_n == w_v);
            4'b1011: w_cond = (w_n != w_v);
            4'b1100: w_cond = !w_z && (w_n == w_v);
            4'b1101: w_cond = w_z || (w_n != w_v);
            4'b1110: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_anyPend = 1'b0;
        for (int k = 1; k <= PD; k++) begin
            if (k <= LAST_COUNTED && r_pend[k] != 2'b00) begin
                w_anyPend = 1'b1;
            end
        end
    end

    assign w_stall   = w_anyPend && (Cond != 4'b1110) && (Cond != 4'b1111);
    assign w_qual    = reset & w_cond & ~w_stall;
    assign w_land    = (WB_DELAY == 0) ? (FlagW & {2{w_cond}}) : r_pend[PD];

    assign CondEx    = w_cond;
    assign CondStall = w_stall;
    assign RegWrite  = RegW & w_qual;
    assign MemWrite  = MemW & w_qual;
    assign PCWrite   = (NextPC & ~w_stall & reset) | (PCS & w_qual);
    assign Flags     = r_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= PD; k++) begin
                r_pend[k] <= 2'b00;
            end
        end else begin
            r_pend[1] <= (WB_DELAY > 0) ? (FlagW & {2{w_qual}}) : 2'b00;
            for (int k = 2; k <= PD; k++) begin
                r_pend[k] <= r_pend[k-1];
            end
        end
    end

    // Restore beats a landing write; save always captures the pre-edge flags, so doing
    // both in one edge swaps the two registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags  <= 4'b0000;
            r_shadow <= 4'b0000;
        end else begin
            if (FlagSave) begin
                r_shadow <= r_flags;
            end
            if (FlagRestore) begin
                r_flags <= r_shadow;
            end else begin
                if (w_land[1]) begin
                    r_flags[3:2] <= ALUFlags[3:2];
                end
                if (w_land[0]) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

endmodule
